// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet layer scheduler.
// Contents: layer ids, default SRAM base addresses and the FSM state encoding.
package lenet_pkg;

  localparam int NUM_LAYERS = 5;

  localparam logic [2:0] LAYER_CONV1 = 3'd0;
  localparam logic [2:0] LAYER_CONV2 = 3'd1;
  localparam logic [2:0] LAYER_CONV3 = 3'd2;
  localparam logic [2:0] LAYER_FC1   = 3'd3;
  localparam logic [2:0] LAYER_FC2   = 3'd4;

  localparam logic [9:0] ACT_BASE_IMG   = 10'd0;
  localparam logic [9:0] ACT_BASE_CONV1 = 10'd256;
  localparam logic [9:0] ACT_BASE_CONV2 = 10'd592;
  localparam logic [9:0] ACT_BASE_CONV3 = 10'd692;
  localparam logic [9:0] ACT_BASE_FC1   = 10'd722;
  localparam logic [9:0] ACT_BASE_FC2   = 10'd743;

  localparam logic [13:0] WGT_BASE_CONV1 = 14'd0;
  localparam logic [13:0] WGT_BASE_CONV2 = 14'd60;
  localparam logic [13:0] WGT_BASE_CONV3 = 14'd1020;
  localparam logic [13:0] WGT_BASE_FC1   = 14'd13020;
  localparam logic [13:0] WGT_BASE_FC2   = 14'd15540;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/lenet_layer_sched.sv
// Layer scheduler: steps the shared engine through CONV1..FC2, decodes per-layer
// scale and SRAM bases, guards each layer with a watchdog and counts busy cycles.
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int          TIMEOUT      = 20000,
  parameter logic [13:0] W_BASE_CONV1 = WGT_BASE_CONV1,
  parameter logic [13:0] W_BASE_CONV2 = WGT_BASE_CONV2,
  parameter logic [13:0] W_BASE_CONV3 = WGT_BASE_CONV3,
  parameter logic [13:0] W_BASE_FC1   = WGT_BASE_FC1,
  parameter logic [13:0] W_BASE_FC2   = WGT_BASE_FC2,
  parameter logic [9:0]  A_BASE_IMG   = ACT_BASE_IMG,
  parameter logic [9:0]  A_BASE_CONV1 = ACT_BASE_CONV1,
  parameter logic [9:0]  A_BASE_CONV2 = ACT_BASE_CONV2,
  parameter logic [9:0]  A_BASE_CONV3 = ACT_BASE_CONV3,
  parameter logic [9:0]  A_BASE_FC1   = ACT_BASE_FC1,
  parameter logic [9:0]  A_BASE_FC2   = ACT_BASE_FC2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        compute_start,
  input  logic [31:0] scale_CONV1,
  input  logic [31:0] scale_CONV2,
  input  logic [31:0] scale_CONV3,
  input  logic [31:0] scale_FC1,
  input  logic [31:0] scale_FC2,
  input  logic        layer_done,
  output logic        layer_start,
  output logic [2:0]  layer_id,
  output logic [31:0] layer_scale,
  output logic [13:0] wgt_base,
  output logic [9:0]  act_rd_base,
  output logic [9:0]  act_wr_base,
  output logic        busy,
  output logic        compute_finish,
  output logic        error,
  output logic [2:0]  err_layer,
  output logic [31:0] total_cycles
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e          state;
  state_e          state_n;
  logic [WD_W-1:0] wd;
  logic            accept;
  logic            wait_done;
  logic            timeout;

  assign accept    = (state == ST_IDLE) && compute_start;
  assign wait_done = (state == ST_WAIT) && layer_done;
  // A done pulse on the watchdog's last cycle takes priority over the timeout.
  assign timeout   = (state == ST_WAIT) && !layer_done && (wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (compute_start) state_n = ST_ISSUE;
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (layer_done)  state_n = (layer_id == LAYER_FC2) ? ST_FIN : ST_ISSUE;
        else if (timeout) state_n = ST_FIN;
      end
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    layer_start = (state == ST_ISSUE);
    busy        = (state == ST_ISSUE) || (state == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer_id       <= LAYER_CONV1;
      wd             <= '0;
      compute_finish <= 1'b0;
      error          <= 1'b0;
      err_layer      <= 3'd0;
      total_cycles   <= 32'd0;
    end else begin
      if (accept) begin
        layer_id       <= LAYER_CONV1;
        compute_finish <= 1'b0;
        error          <= 1'b0;
        total_cycles   <= 32'd0;
      end
      if (busy) total_cycles <= sat_inc(total_cycles);
      if (state == ST_ISSUE)     wd <= '0;
      else if (state == ST_WAIT) wd <= wd + WD_W'(1);
      if (wait_done) begin
        if (layer_id == LAYER_FC2) compute_finish <= 1'b1;
        else                       layer_id       <= layer_id + 3'd1;
      end
      if (timeout) begin
        compute_finish <= 1'b1;
        error          <= 1'b1;
        err_layer      <= layer_id;
      end
    end
  end

  // Each layer reads what the previous layer wrote; CONV1 reads the input image.
  always_comb begin
    layer_scale = 32'd0;
    wgt_base    = W_BASE_CONV1;
    act_rd_base = A_BASE_IMG;
    act_wr_base = A_BASE_CONV1;
    case (layer_id)
      LAYER_CONV1: begin
        layer_scale = scale_CONV1;
        wgt_base    = W_BASE_CONV1;
        act_rd_base = A_BASE_IMG;
        act_wr_base = A_BASE_CONV1;
      end
      LAYER_CONV2: begin
        layer_scale = scale_CONV2;
        wgt_base    = W_BASE_CONV2;
        act_rd_base = A_BASE_CONV1;
        act_wr_base = A_BASE_CONV2;
      end
      LAYER_CONV3: begin
        layer_scale = scale_CONV3;
        wgt_base    = W_BASE_CONV3;
        act_rd_base = A_BASE_CONV2;
        act_wr_base = A_BASE_CONV3;
      end
      LAYER_FC1: begin
        layer_scale = scale_FC1;
        wgt_base    = W_BASE_FC1;
        act_rd_base = A_BASE_CONV3;
        act_wr_base = A_BASE_FC1;
      end
      LAYER_FC2: begin
        layer_scale = scale_FC2;
        wgt_base    = W_BASE_FC2;
        act_rd_base = A_BASE_FC1;
        act_wr_base = A_BASE_FC2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Self-checking bench for lenet_layer_sched: directed layer table, corner-case
// sequences and randomized engine latencies against a run-level timing model.
module tb_lenet_layer_sched;

  localparam int TMO = 100;

  typedef struct {
    logic [31:0] scale;
    logic [2:0]  id;
    logic [9:0]  rd;
    logic [9:0]  wr;
    logic [13:0] wgt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        compute_start;
  logic        layer_done;
  logic [31:0] sc [5];
  logic        layer_start;
  logic [2:0]  layer_id;
  logic [31:0] layer_scale;
  logic [13:0] wgt_base;
  logic [9:0]  act_rd_base;
  logic [9:0]  act_wr_base;
  logic        busy;
  logic        compute_finish;
  logic        error;
  logic [2:0]  err_layer;
  logic [31:0] total_cycles;

  vec_t tbl [5];
  int   lat [5];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  lenet_layer_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .compute_start(compute_start),
    .scale_CONV1(sc[0]), .scale_CONV2(sc[1]), .scale_CONV3(sc[2]),
    .scale_FC1(sc[3]), .scale_FC2(sc[4]),
    .layer_done(layer_done), .layer_start(layer_start), .layer_id(layer_id),
    .layer_scale(layer_scale), .wgt_base(wgt_base), .act_rd_base(act_rd_base),
    .act_wr_base(act_wr_base), .busy(busy), .compute_finish(compute_finish),
    .error(error), .err_layer(err_layer), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Run-level model: each layer costs its latency plus one issue cycle;
  // a layer slower than the watchdog costs TMO+1 and ends the run.
  function automatic int exp_total();
    int s = 0;
    for (int k = 0; k < 5; k++) begin
      if (lat[k] > TMO) return s + TMO + 1;
      s += lat[k] + 1;
    end
    return s;
  endfunction

  function automatic int exp_err_layer();
    for (int k = 0; k < 5; k++) if (lat[k] > TMO) return k;
    return -1;
  endfunction

  task automatic chk_reset();
    chk("rst_layer_start", 32'(layer_start), 32'd0);
    chk("rst_layer_id", 32'(layer_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(compute_finish), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_layer", 32'(err_layer), 32'd0);
    chk("rst_total", total_cycles, 32'd0);
    chk("rst_act_rd", 32'(act_rd_base), 32'(tbl[0].rd));
    chk("rst_act_wr", 32'(act_wr_base), 32'(tbl[0].wr));
    chk("rst_wgt", 32'(wgt_base), 32'(tbl[0].wgt));
    chk("rst_scale", layer_scale, sc[0]);
  endtask

  task automatic do_run(input int start_inj, input int rst_layer);
    int t0;
    int tot;
    int err_k;
    bit to;
    tot   = exp_total();
    err_k = exp_err_layer();
    to    = 1'b0;
    @(negedge clk); compute_start = 1'b1;
    @(negedge clk); compute_start = 1'b0;
    t0 = cyc;
    chk("start_finish_clr", 32'(compute_finish), 32'd0);
    chk("start_error_clr", 32'(error), 32'd0);
    chk("start_total_clr", total_cycles, 32'd0);
    for (int k = 0; k < 5 && !to; k++) begin
      chk("issue_layer_start", 32'(layer_start), 32'd1);
      chk("issue_busy", 32'(busy), 32'd1);
      chk("issue_layer_id", 32'(layer_id), 32'(tbl[k].id));
      chk("issue_act_rd", 32'(act_rd_base), 32'(tbl[k].rd));
      chk("issue_act_wr", 32'(act_wr_base), 32'(tbl[k].wr));
      chk("issue_wgt", 32'(wgt_base), 32'(tbl[k].wgt));
      for (int w = 1; w <= TMO; w++) begin
        @(negedge clk);
        compute_start = (k == start_inj && w == 2);
        if (w == 1) begin
          chk("wait_layer_start", 32'(layer_start), 32'd0);
          chk("wait_scale", layer_scale, sc[k]);
          chk("wait_layer_id", 32'(layer_id), 32'(tbl[k].id));
        end
        if (k == rst_layer && w == 3) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (w == lat[k]) begin
          layer_done = 1'b1;
          @(negedge clk);
          layer_done    = 1'b0;
          compute_start = 1'b0;
          break;
        end
        if (w == TMO) begin
          @(negedge clk);
          to = 1'b1;
        end
      end
    end
    chk("fin_finish", 32'(compute_finish), 32'd1);
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_layer_start", 32'(layer_start), 32'd0);
    chk("fin_error", 32'(error), (err_k >= 0) ? 32'd1 : 32'd0);
    if (err_k >= 0) chk("fin_err_layer", 32'(err_layer), 32'(err_k));
    chk("fin_total", total_cycles, 32'(tot));
    chk("finish_latency", 32'(cyc - t0), 32'(tot));
    @(negedge clk);
    chk("idle_finish_held", 32'(compute_finish), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_total_held", total_cycles, 32'(tot));
  endtask

  initial begin
    tbl[0] = '{32'd91,  3'd0, 10'd0,   10'd256, 14'd0};
    tbl[1] = '{32'd257, 3'd1, 10'd256, 10'd592, 14'd60};
    tbl[2] = '{32'd287, 3'd2, 10'd592, 10'd692, 14'd1020};
    tbl[3] = '{32'd427, 3'd3, 10'd692, 10'd722, 14'd13020};
    tbl[4] = '{32'd321, 3'd4, 10'd722, 10'd743, 14'd15540};
    for (int k = 0; k < 5; k++) sc[k] = tbl[k].scale;
    rst = 1'b1;
    compute_start = 1'b0;
    layer_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    // Nominal run, fixed latency 10: 55 busy cycles
    for (int k = 0; k < 5; k++) lat[k] = 10;
    do_run(-1, -1);
    chk("total_55", total_cycles, 32'd55);

    // CONV3 never answers
    lat[2] = 500;
    do_run(-1, -1);
    chk("timeout_err_layer", 32'(err_layer), 32'd2);
    chk("timeout_error", 32'(error), 32'd1);

    // Reset in the middle of CONV2, then a clean run
    lat[2] = 10;
    do_run(-1, 1);
    chk_reset();
    do_run(-1, -1);

    // Stray compute_start in FC1 WAIT, stray layer_done in IDLE
    do_run(3, -1);
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
    chk("idle_done_layer_id", 32'(layer_id), 32'd4);
    chk("idle_done_total", total_cycles, 32'd55);
    chk("idle_done_finish", 32'(compute_finish), 32'd1);
    chk("idle_done_start", 32'(layer_start), 32'd0);
    @(negedge clk);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_start2", 32'(layer_start), 32'd0);

    // Minimum engine latency
    for (int k = 0; k < 5; k++) lat[k] = 1;
    do_run(-1, -1);
    chk("total_min", total_cycles, 32'd10);

    // Done on the watchdog's last cycle must not raise an error
    for (int k = 0; k < 5; k++) lat[k] = 2;
    lat[4] = TMO;
    do_run(-1, -1);

    // Randomized latencies and scales
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 5; k++) begin
        lat[k] = int'($urandom_range(1, 20));
        sc[k]  = $urandom;
      end
      if (r == 3) lat[$urandom_range(0, 4)] = TMO;
      if (r == 5) lat[$urandom_range(0, 4)] = TMO + 1 + int'($urandom_range(0, 5));
      do_run(-1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
